// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - N-master byte-bus arbiter with RAM/IO decode and read-return routing
module mem_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int IO_SEL_WIDTH   = 3
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [NUM_MASTERS-1:0]            m_req_in,
  input  logic [NUM_MASTERS-1:0]            m_lock_in,
  input  logic [NUM_MASTERS-1:0]            m_wr_in,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_a_in,
  input  logic [NUM_MASTERS*8-1:0]          m_dout_in,
  output logic [NUM_MASTERS-1:0]            m_gnt_out,
  output logic [NUM_MASTERS-1:0]            m_rvalid_out,
  output logic [7:0]                        m_din_out,
  output logic                              ram_en_out,
  output logic                              ram_r_nw_out,
  output logic [RAM_ADDR_WIDTH-1:0]         ram_a_out,
  output logic [7:0]                        ram_d_out,
  input  logic [7:0]                        ram_d_in,
  output logic                              io_en_out,
  output logic                              io_wr_out,
  output logic [IO_SEL_WIDTH-1:0]           io_sel_out,
  output logic [7:0]                        io_d_out,
  input  logic [7:0]                        io_d_in
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] lock_owner_q, lock_owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             rd_pend_q, rd_pend_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             rd_io_q, rd_io_d;

  logic                  hold_lock;
  logic                  gnt_any;
  logic [IDX_W-1:0]      gnt_idx;
  logic [IDX_W-1:0]      scan_idx;
  int                    scan_j;
  logic [ADDR_WIDTH-1:0] sel_a;
  logic [7:0]            sel_d;
  logic                  sel_wr;
  logic                  sel_lock;
  logic                  sel_io;
  logic                  unused_addr_bits;

  // Pick the master for this cycle: locked owner, else priority master 0, else round-robin scan
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    scan_j    = 0;
    scan_idx  = '0;
    hold_lock = (state_q == ST_LOCKED) && m_lock_in[lock_owner_q];
    if (!rst_in) begin
      if (hold_lock) begin
        if (m_req_in[lock_owner_q]) begin
          gnt_any = 1'b1;
          gnt_idx = lock_owner_q;
        end
      end else if (m_req_in[0]) begin
        gnt_any = 1'b1;
        gnt_idx = '0;
      end else begin
        for (int k = 0; k < NUM_MASTERS; k++) begin
          scan_j = int'(rr_ptr_q) + k;
          if (scan_j >= NUM_MASTERS) scan_j = scan_j - NUM_MASTERS;
          scan_idx = IDX_W'(scan_j);
          if (!gnt_any && m_req_in[scan_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = scan_idx;
          end
        end
      end
    end
  end

  // Mux the granted master's address, data and control onto shared signals
  always_comb begin
    sel_a    = '0;
    sel_d    = '0;
    sel_wr   = 1'b0;
    sel_lock = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        sel_a    = m_a_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_d    = m_dout_in[i*8 +: 8];
        sel_wr   = m_wr_in[i];
        sel_lock = m_lock_in[i];
      end
    end
    sel_io = (sel_a[RAM_ADDR_WIDTH -: 2] == 2'b11);
  end

  assign unused_addr_bits = ^sel_a;

  // Drive the grant vector and decode the granted access onto the RAM or IO port
  always_comb begin
    m_gnt_out    = '0;
    ram_en_out   = 1'b0;
    ram_r_nw_out = 1'b1;
    ram_a_out    = '0;
    ram_d_out    = '0;
    io_en_out    = 1'b0;
    io_wr_out    = 1'b0;
    io_sel_out   = '0;
    io_d_out     = '0;
    if (gnt_any) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (gnt_idx == IDX_W'(i)) m_gnt_out[i] = 1'b1;
      end
      ram_d_out = sel_d;
      io_d_out  = sel_d;
      if (sel_io) begin
        io_en_out  = 1'b1;
        io_wr_out  = sel_wr;
        io_sel_out = sel_a[IO_SEL_WIDTH-1:0];
      end else begin
        ram_en_out   = 1'b1;
        ram_r_nw_out = ~sel_wr;
        ram_a_out    = sel_a[RAM_ADDR_WIDTH-1:0];
      end
    end
  end

  // Next-state: lock entry/exit, round-robin advance, and capture of an outstanding read
  always_comb begin
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    rr_ptr_d     = rr_ptr_q;
    rd_pend_d    = 1'b0;
    rd_idx_d     = rd_idx_q;
    rd_io_d      = rd_io_q;
    if (hold_lock) begin
      state_d = ST_LOCKED;
    end else begin
      state_d = ST_IDLE;
      if (gnt_any) begin
        if (int'(gnt_idx) + 1 >= NUM_MASTERS) rr_ptr_d = '0;
        else rr_ptr_d = gnt_idx + IDX_W'(1);
        if (sel_lock) begin
          state_d      = ST_LOCKED;
          lock_owner_d = gnt_idx;
        end
      end
    end
    if (gnt_any && !sel_wr) begin
      rd_pend_d = 1'b1;
      rd_idx_d  = gnt_idx;
      rd_io_d   = sel_io;
    end
  end

  // State and read-tracking registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      lock_owner_q <= '0;
      rr_ptr_q     <= '0;
      rd_pend_q    <= 1'b0;
      rd_idx_q     <= '0;
      rd_io_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
      rr_ptr_q     <= rr_ptr_d;
      rd_pend_q    <= rd_pend_d;
      rd_idx_q     <= rd_idx_d;
      rd_io_q      <= rd_io_d;
    end
  end

  // Return read data to the master that issued the read one cycle earlier
  always_comb begin
    m_rvalid_out = '0;
    m_din_out    = '0;
    if (rd_pend_q) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (rd_idx_q == IDX_W'(i)) m_rvalid_out[i] = 1'b1;
      end
      m_din_out = rd_io_q ? io_d_in : ram_d_in;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter with four masters
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic [3:0]   req = '0, lock = '0, wr = '0;
  logic [127:0] a_bus = '0;
  logic [31:0]  d_bus = '0;
  logic [3:0]   gnt, rvalid;
  logic [7:0]   din;
  logic         ram_en, ram_r_nw, io_en, io_wr;
  logic [16:0]  ram_a;
  logic [7:0]   ram_d_o, io_d_o;
  logic [7:0]   ram_d_i = '0, io_d_i = '0;
  logic [2:0]   io_sel;
  logic [31:0]  ma [4];
  logic [7:0]   md [4];

  mem_bus_arbiter #(
    .NUM_MASTERS(4), .ADDR_WIDTH(32), .RAM_ADDR_WIDTH(17), .IO_SEL_WIDTH(3)
  ) dut (
    .clk_in(clk), .rst_in(rst),
    .m_req_in(req), .m_lock_in(lock), .m_wr_in(wr),
    .m_a_in(a_bus), .m_dout_in(d_bus),
    .m_gnt_out(gnt), .m_rvalid_out(rvalid), .m_din_out(din),
    .ram_en_out(ram_en), .ram_r_nw_out(ram_r_nw), .ram_a_out(ram_a),
    .ram_d_out(ram_d_o), .ram_d_in(ram_d_i),
    .io_en_out(io_en), .io_wr_out(io_wr), .io_sel_out(io_sel),
    .io_d_out(io_d_o), .io_d_in(io_d_i)
  );

  // Memory models: read data appears the cycle after the read
  always @(posedge clk) begin
    if (ram_en && ram_r_nw) ram_d_i <= ram_a[7:0] ^ 8'h5A;
    if (io_en && !io_wr) io_d_i <= {5'b11000, io_sel};
  end

  typedef struct {
    logic [3:0]  gnt;
    logic        ram_en;
    logic        ram_r_nw;
    logic [16:0] ram_a;
    logic        io_en;
    logic        io_wr;
    logic [2:0]  io_sel;
    logic [7:0]  d;
    logic        chk_d;
    logic        din0;
  } exp_t;

  typedef struct {
    int         due;
    logic [3:0] rv;
    logic [7:0] data;
  } rd_t;

  exp_t exp_q[$];
  rd_t  rd_q[$];
  exp_t me;
  rd_t  mr;
  int   total = 0;
  int   bad = 0;
  int   cyc_n = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc_n);
    end
  endtask

  function automatic exp_t x_none(input logic z);
    exp_t e;
    e = '{gnt: 4'b0, ram_en: 1'b0, ram_r_nw: 1'b1, ram_a: 17'h0, io_en: 1'b0,
          io_wr: 1'b0, io_sel: 3'h0, d: 8'h0, chk_d: 1'b0, din0: z};
    return e;
  endfunction

  function automatic exp_t x_ram(input logic [3:0] g, input logic rnw,
                                 input logic [16:0] a, input logic [7:0] d);
    exp_t e;
    e = '{gnt: g, ram_en: 1'b1, ram_r_nw: rnw, ram_a: a, io_en: 1'b0,
          io_wr: 1'b0, io_sel: 3'h0, d: d, chk_d: ~rnw, din0: 1'b0};
    return e;
  endfunction

  function automatic exp_t x_io(input logic [3:0] g, input logic w,
                                input logic [2:0] s, input logic [7:0] d);
    exp_t e;
    e = '{gnt: g, ram_en: 1'b0, ram_r_nw: 1'b1, ram_a: 17'h0, io_en: 1'b1,
          io_wr: w, io_sel: s, d: d, chk_d: w, din0: 1'b0};
    return e;
  endfunction

  // Drive one cycle of stimulus and queue what the DUT must present for it
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                      input logic [3:0] w, input exp_t e,
                      input logic rdx, input logic [3:0] rv, input logic [7:0] rdd);
    rd_t t;
    @(posedge clk);
    #1;
    rst = r; req = rq; lock = lk; wr = w;
    for (int i = 0; i < 4; i++) begin
      a_bus[i*32 +: 32] = ma[i];
      d_bus[i*8 +: 8]   = md[i];
    end
    exp_q.push_back(e);
    if (rdx) begin
      t.due = cyc_n + 1; t.rv = rv; t.data = rdd;
      rd_q.push_back(t);
    end
  endtask

  // Monitor: compare access decode every cycle, and read returns when they fall due
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      chk("gnt", 32'(gnt), 32'(me.gnt));
      chk("ram_en", 32'(ram_en), 32'(me.ram_en));
      chk("ram_r_nw", 32'(ram_r_nw), 32'(me.ram_r_nw));
      chk("io_en", 32'(io_en), 32'(me.io_en));
      chk("io_wr", 32'(io_wr), 32'(me.io_wr));
      if (me.ram_en) chk("ram_a", 32'(ram_a), 32'(me.ram_a));
      if (me.io_en) chk("io_sel", 32'(io_sel), 32'(me.io_sel));
      if (me.chk_d) begin
        chk("ram_d_out", 32'(ram_d_o), 32'(me.d));
        chk("io_d_out", 32'(io_d_o), 32'(me.d));
      end
      if (me.din0) chk("din_reset", 32'(din), 32'h0);
    end
    if (rd_q.size() > 0 && rd_q[0].due == cyc_n) begin
      mr = rd_q.pop_front();
      chk("rvalid", 32'(rvalid), 32'(mr.rv));
      chk("rdata", 32'(din), 32'(mr.data));
    end else begin
      chk("rvalid_idle", 32'(rvalid), 32'h0);
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin ma[i] = '0; md[i] = '0; end

    // Reset with all masters requesting: no grant, no read return
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, x_none(1'b1), 1'b0, 4'b0, 8'h0);
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, x_none(1'b1), 1'b0, 4'b0, 8'h0);

    // Single master RAM read at 0x10
    ma[1] = 32'h0001_0; md[1] = 8'h00;
    step(1'b0, 4'b0010, 4'b0000, 4'b0000, x_ram(4'b0010, 1'b1, 17'h10, 8'h0), 1'b1, 4'b0010, 8'h4A);

    // IO write 0x30004 = 0x41, then IO read at 0x30000
    ma[1] = 32'h0003_0004; md[1] = 8'h41;
    step(1'b0, 4'b0010, 4'b0000, 4'b0010, x_io(4'b0010, 1'b1, 3'd4, 8'h41), 1'b0, 4'b0, 8'h0);
    ma[1] = 32'h0003_0000;
    step(1'b0, 4'b0010, 4'b0000, 4'b0000, x_io(4'b0010, 1'b0, 3'd0, 8'h0), 1'b1, 4'b0010, 8'hC0);

    // Pipelined reads: M1 RAM then M2 IO on consecutive cycles
    ma[1] = 32'h0000_0025; ma[2] = 32'h0003_0003;
    step(1'b0, 4'b0010, 4'b0000, 4'b0000, x_ram(4'b0010, 1'b1, 17'h25, 8'h0), 1'b1, 4'b0010, 8'h7F);
    step(1'b0, 4'b0100, 4'b0000, 4'b0000, x_io(4'b0100, 1'b0, 3'd3, 8'h0), 1'b1, 4'b0100, 8'hC3);
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, x_none(1'b0), 1'b0, 4'b0, 8'h0);

    // Round robin among M1..M3 (pointer is at 3), then M0 priority
    ma[0] = 32'h50;  md[0] = 8'hA0;
    ma[1] = 32'h100; md[1] = 8'h11;
    ma[2] = 32'h200; md[2] = 8'h22;
    ma[3] = 32'h300; md[3] = 8'h33;
    step(1'b0, 4'b1110, 4'b0000, 4'b1110, x_ram(4'b1000, 1'b0, 17'h300, 8'h33), 1'b0, 4'b0, 8'h0);
    step(1'b0, 4'b1110, 4'b0000, 4'b1110, x_ram(4'b0010, 1'b0, 17'h100, 8'h11), 1'b0, 4'b0, 8'h0);
    step(1'b0, 4'b1110, 4'b0000, 4'b1110, x_ram(4'b0100, 1'b0, 17'h200, 8'h22), 1'b0, 4'b0, 8'h0);
    step(1'b0, 4'b1110, 4'b0000, 4'b1110, x_ram(4'b1000, 1'b0, 17'h300, 8'h33), 1'b0, 4'b0, 8'h0);
    step(1'b0, 4'b1110, 4'b0000, 4'b1110, x_ram(4'b0010, 1'b0, 17'h100, 8'h11), 1'b0, 4'b0, 8'h0);
    step(1'b0, 4'b1111, 4'b0000, 4'b1111, x_ram(4'b0001, 1'b0, 17'h50, 8'hA0), 1'b0, 4'b0, 8'h0);
    step(1'b0, 4'b1111, 4'b0000, 4'b1111, x_ram(4'b0001, 1'b0, 17'h50, 8'hA0), 1'b0, 4'b0, 8'h0);
    step(1'b0, 4'b1110, 4'b0000, 4'b1110, x_ram(4'b0010, 1'b0, 17'h100, 8'h11), 1'b0, 4'b0, 8'h0);

    // Lock: M2 holds the bus for 4 cycles against M0/M1, then idles while still locked
    step(1'b0, 4'b0100, 4'b0100, 4'b0100, x_ram(4'b0100, 1'b0, 17'h200, 8'h22), 1'b0, 4'b0, 8'h0);
    step(1'b0, 4'b0111, 4'b0100, 4'b0111, x_ram(4'b0100, 1'b0, 17'h200, 8'h22), 1'b0, 4'b0, 8'h0);
    step(1'b0, 4'b0111, 4'b0100, 4'b0111, x_ram(4'b0100, 1'b0, 17'h200, 8'h22), 1'b0, 4'b0, 8'h0);
    step(1'b0, 4'b0111, 4'b0100, 4'b0111, x_ram(4'b0100, 1'b0, 17'h200, 8'h22), 1'b0, 4'b0, 8'h0);
    step(1'b0, 4'b0011, 4'b0100, 4'b0011, x_none(1'b0), 1'b0, 4'b0, 8'h0);
    // Lock dropped: pointer still 3 from lock entry, so M3 wins over M1; then M0
    step(1'b0, 4'b1010, 4'b0000, 4'b1010, x_ram(4'b1000, 1'b0, 17'h300, 8'h33), 1'b0, 4'b0, 8'h0);
    step(1'b0, 4'b0011, 4'b0000, 4'b0011, x_ram(4'b0001, 1'b0, 17'h50, 8'hA0), 1'b0, 4'b0, 8'h0);

    // Reset mid-op: locked M2 read, reset next cycle, then M0 wins despite M2 lock
    ma[2] = 32'h33;
    step(1'b0, 4'b0100, 4'b0100, 4'b0000, x_ram(4'b0100, 1'b1, 17'h33, 8'h0), 1'b1, 4'b0100, 8'h69);
    step(1'b1, 4'b0111, 4'b0100, 4'b0000, x_none(1'b0), 1'b0, 4'b0, 8'h0);
    step(1'b0, 4'b0111, 4'b0100, 4'b0001, x_ram(4'b0001, 1'b0, 17'h50, 8'hA0), 1'b0, 4'b0, 8'h0);
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, x_none(1'b0), 1'b0, 4'b0, 8'h0);
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, x_none(1'b0), 1'b0, 4'b0, 8'h0);

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rd_q_drained", 32'(rd_q.size()), 32'h0);
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
